alu_calc: RTL and testbench

Parametrised, clocked successor to the board-level switch ALU wrapper. It adds a registered W-bit result and Z/N/C/V flag register, an accumulator mode (ACC op B), and a synchronised, debounced push-button execute strobe. It also drives a registered active-low 7-segment digit for every result nibble. It sits at the top of the switch/LED/HEX lab designs and replaces purely combinational operate-on-switch behaviour with one operation per button press.

---
 rtl/alu_calc.sv | 197 +++++++++++++++++++
 tb/tb_alu_calc.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_calc.sv
// Clocked switch ALU: debounced push-button execute, registered result/flags,
// accumulator chaining and active-low 7-segment display of every result nibble.
module alu_calc #(
    parameter int W         = 8,
    parameter int DB_CYCLES = 16,
    localparam int NDIG     = W / 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [W-1:0]        a_in,
    input  logic [W-1:0]        b_in,
    input  logic [2:0]          op,
    input  logic                mode,
    input  logic                step_n,
    output logic                exec,
    output logic [W-1:0]        result,
    output logic [3:0]          flags,
    output logic [7*NDIG-1:0]   hex_seg
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_REL, IDLE, ARMING, PRESSED} db_state_t;

    logic            sync1_reg, sync2_reg;
    db_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            exec_reg, exec_next;
    logic [W-1:0]    result_reg, acc_reg;
    logic [3:0]      flags_reg;
    logic [6:0]      hex_reg [NDIG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= step_n;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAIT_REL;
            cnt_reg   <= '0;
            exec_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            exec_reg  <= exec_next;
        end
    end

    // Debouncer: a press is accepted only once the synced input has been low
    // for the full count; a new press needs a fully debounced release first.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        exec_next  = 1'b0;
        case (state_reg)
            WAIT_REL: begin
                if (!sync2_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            IDLE: begin
                if (!sync2_reg) begin
                    state_next = ARMING;
                    cnt_next   = CNT_ONE;
                end
            end
            ARMING: begin
                if (sync2_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_FULL) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    exec_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            PRESSED: begin
                if (sync2_reg) begin
                    state_next = WAIT_REL;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = WAIT_REL;
                cnt_next   = '0;
            end
        endcase
    end

    logic [W-1:0] x_opnd, alu_res;
    logic [W:0]   add_full, sub_full;
    logic         alu_c, alu_v;

    assign x_opnd   = mode ? acc_reg : a_in;
    assign add_full = {1'b0, x_opnd} + {1'b0, b_in};
    assign sub_full = {1'b0, x_opnd} - {1'b0, b_in};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'b000: begin
                alu_res = add_full[W-1:0];
                alu_c   = add_full[W];
                alu_v   = (x_opnd[W-1] == b_in[W-1]) && (alu_res[W-1] != x_opnd[W-1]);
            end
            3'b001: begin
                alu_res = sub_full[W-1:0];
                alu_c   = ~sub_full[W];
                alu_v   = (x_opnd[W-1] != b_in[W-1]) && (alu_res[W-1] != x_opnd[W-1]);
            end
            3'b010: alu_res = x_opnd & b_in;
            3'b011: alu_res = x_opnd | b_in;
            3'b100: alu_res = x_opnd ^ b_in;
            3'b101: begin
                alu_res = {x_opnd[W-2:0], 1'b0};
                alu_c   = x_opnd[W-1];
            end
            3'b110: begin
                alu_res = {1'b0, x_opnd[W-1:1]};
                alu_c   = x_opnd[0];
            end
            default: alu_res = b_in;
        endcase
    end

    // ACC always follows the result so mode 1 chains from the last operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
            flags_reg  <= 4'b0000;
            acc_reg    <= '0;
        end else if (exec_reg) begin
            result_reg <= alu_res;
            flags_reg  <= {(alu_res == '0), alu_res[W-1], alu_c, alu_v};
            acc_reg    <= alu_res;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hex_reg[gi] <= 7'b1000000;
                end else begin
                    hex_reg[gi] <= seg7(result_reg[4*gi +: 4]);
                end
            end
            assign hex_seg[7*gi +: 7] = hex_reg[gi];
        end
    endgenerate

    assign exec   = exec_reg;
    assign result = result_reg;
    assign flags  = flags_reg;

endmodule

// File: tb/tb_alu_calc.sv
// Directed bench for alu_calc (W=8, DB_CYCLES=4): reset, ADD/SUB, bounce,
// accumulator chain and reset during arming.
module tb_alu_calc;

    localparam int W  = 8;
    localparam int DB = 4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a_in, b_in;
    logic [2:0]  op;
    logic        mode;
    logic        step_n;
    logic        exec;
    logic [7:0]  result;
    logic [3:0]  flags;
    logic [13:0] hex_seg;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int exec_count   = 0;
    int last_exec_cyc = 0;

    alu_calc #(.W(W), .DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_in    (a_in),
        .b_in    (b_in),
        .op      (op),
        .mode    (mode),
        .step_n  (step_n),
        .exec    (exec),
        .result  (result),
        .flags   (flags),
        .hex_seg (hex_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (exec === 1'b1) begin
            exec_count    <= exec_count + 1;
            last_exec_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full press: released, held low 12 cycles, released 10 cycles.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] o, input logic m, input logic [7:0] exp_res,
                         input logic [3:0] exp_flags, input logic [13:0] exp_hex);
        int base, fall;
        a_in = a; b_in = b; op = o; mode = m;
        step_n = 1'b1;
        wait_cyc(10);
        base   = exec_count;
        step_n = 1'b0;
        fall   = cyc + 1;
        wait_cyc(12);
        step_n = 1'b1;
        wait_cyc(10);
        check({tag, "_exec_cnt"}, 32'(exec_count - base), 32'd1);
        check({tag, "_latency"}, 32'(last_exec_cyc - fall), 32'd6);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
        check({tag, "_hex"}, 32'(hex_seg), 32'(exp_hex));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst_n = 1'b0; step_n = 1'b0;
        a_in = '0; b_in = '0; op = '0; mode = 1'b0;

        // Reset with the button held down throughout
        wait_cyc(3);
        check("rst_result", 32'(result), 32'h00);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_hex", 32'(hex_seg), 32'({7'b1000000, 7'b1000000}));
        check("rst_exec", 32'(exec), 32'd0);
        rst_n = 1'b1;
        wait_cyc(15);
        check("held_no_exec", 32'(exec_count), 32'd0);

        do_op("add", 8'h7F, 8'h01, 3'b000, 1'b0, 8'h80, 4'b0101, {7'b0000000, 7'b1000000});
        do_op("sub_neg", 8'h10, 8'h20, 3'b001, 1'b0, 8'hF0, 4'b0100, {7'b0001110, 7'b1000000});
        do_op("sub_zero", 8'h55, 8'h55, 3'b001, 1'b0, 8'h00, 4'b1010, {7'b1000000, 7'b1000000});

        // Bouncing press then bouncing release
        a_in = 8'hF0; b_in = 8'h3C; op = 3'b010; mode = 1'b0;
        step_n = 1'b1;
        wait_cyc(10);
        base = exec_count;
        for (int i = 0; i < 5; i++) begin
            step_n = 1'b0; wait_cyc(2);
            step_n = 1'b1; wait_cyc(2);
        end
        step_n = 1'b0;
        wait_cyc(10);
        check("bounce_press_cnt", 32'(exec_count - base), 32'd1);
        base = exec_count;
        for (int i = 0; i < 3; i++) begin
            step_n = 1'b1; wait_cyc(2);
            step_n = 1'b0; wait_cyc(2);
        end
        step_n = 1'b1;
        wait_cyc(10);
        check("bounce_release_cnt", 32'(exec_count - base), 32'd0);
        check("bounce_and_result", 32'(result), 32'h30);
        check("bounce_and_flags", 32'(flags), 32'h0);

        // Accumulator chain
        do_op("acc_pass", 8'hAA, 8'h05, 3'b111, 1'b1, 8'h05, 4'b0000, {7'b1000000, 7'b0010010});
        do_op("acc_add", 8'hAA, 8'hFF, 3'b000, 1'b1, 8'h04, 4'b0010, {7'b1000000, 7'b0011001});
        do_op("acc_shl", 8'hAA, 8'hFF, 3'b101, 1'b1, 8'h08, 4'b0000, {7'b1000000, 7'b0000000});
        do_op("acc_shr", 8'hAA, 8'hFF, 3'b110, 1'b1, 8'h04, 4'b0000, {7'b1000000, 7'b0011001});

        // Reset asserted while arming
        step_n = 1'b1;
        wait_cyc(10);
        base   = exec_count;
        step_n = 1'b0;
        wait_cyc(4);
        rst_n = 1'b0;
        #1;
        check("midarm_result", 32'(result), 32'h00);
        check("midarm_flags", 32'(flags), 32'h0);
        check("midarm_hex", 32'(hex_seg), 32'({7'b1000000, 7'b1000000}));
        check("midarm_exec", 32'(exec), 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(10);
        check("midarm_no_exec", 32'(exec_count - base), 32'd0);

        // ACC was cleared by reset: 0 + 1
        do_op("post_rst_acc", 8'hAA, 8'h01, 3'b000, 1'b1, 8'h01, 4'b0000, {7'b1000000, 7'b1111001});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
